// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port, hazard controls and the IF/ID register outputs.
interface fetch_stage_if;
  logic [31:0] pc_o;
  logic [31:0] instr_i;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;
  logic [31:0] fetch_count_o;

  modport master (
    output pc_o,
    input  instr_i,
    input  stall_i,
    input  flush_i,
    input  redirect_i,
    input  redirect_target_i,
    output if_id_instr_o,
    output if_id_pc_o,
    output if_id_pc4_o,
    output if_id_valid_o,
    output fetch_count_o
  );

  modport slave (
    input  pc_o,
    output instr_i,
    output stall_i,
    output flush_i,
    output redirect_i,
    output redirect_target_i,
    input  if_id_instr_o,
    input  if_id_pc_o,
    input  if_id_pc4_o,
    input  if_id_valid_o,
    input  fetch_count_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, resolves J/JAL from the fetched word with no bubble,
// and fills the IF/ID register subject to redirect/stall/flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master fif
);

  logic [31:0] pc_p0;
  logic [31:0] pc4_p0;
  logic [31:0] jmp_target_p0;
  logic [31:0] redirect_pc_p0;
  logic        is_jump_p0;

  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic [31:0] pc4_p1;
  logic        vld_p1;
  logic [31:0] count_p1;

  // Stage 0: PC register and combinational next-PC sources
  assign pc4_p0         = pc_p0 + 32'd4;
  assign is_jump_p0     = (fif.instr_i[31:27] == 5'b00001);
  assign jmp_target_p0  = {pc4_p0[31:28], fif.instr_i[25:0], 2'b00};
  assign redirect_pc_p0 = fif.redirect_target_i & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0 <= RESET_PC;
    end else if (fif.redirect_i) begin
      pc_p0 <= redirect_pc_p0;
    end else if (!fif.stall_i) begin
      pc_p0 <= is_jump_p0 ? jmp_target_p0 : pc4_p0;
    end
  end

  // Stage 1: IF/ID register; jumps enter like any other word so JAL carries its link value
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_p1 <= 32'd0;
      pc_p1    <= 32'd0;
      pc4_p1   <= 32'd0;
      vld_p1   <= 1'b0;
      count_p1 <= 32'd0;
    end else if (fif.redirect_i || fif.flush_i) begin
      instr_p1 <= 32'd0;
      vld_p1   <= 1'b0;
    end else if (!fif.stall_i) begin
      instr_p1 <= fif.instr_i;
      pc_p1    <= pc_p0;
      pc4_p1   <= pc4_p0;
      vld_p1   <= 1'b1;
      count_p1 <= count_p1 + 32'd1;
    end
  end

  assign fif.pc_o          = pc_p0;
  assign fif.if_id_instr_o = instr_p1;
  assign fif.if_id_pc_o    = pc_p1;
  assign fif.if_id_pc4_o   = pc4_p1;
  assign fif.if_id_valid_o = vld_p1;
  assign fif.fetch_count_o = count_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a 64-word combinational instruction memory and hand-computed
// expectations for sequential fetch, JAL, redirect, stall, flush, wrap and mid-run reset.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] mem [64];

  fetch_stage_if fif ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (fif)
  );

  assign fif.instr_i = mem[fif.pc_o[7:2]];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] pc4, input logic vld, input logic [31:0] cnt);
    check({tag, ".instr"}, fif.if_id_instr_o, instr);
    check({tag, ".pc"},    fif.if_id_pc_o,    pc);
    check({tag, ".pc4"},   fif.if_id_pc4_o,   pc4);
    check({tag, ".valid"}, {31'd0, fif.if_id_valid_o}, {31'd0, vld});
    check({tag, ".count"}, fif.fetch_count_o, cnt);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 + i;
    mem[0]  = 32'h8C10_0000;
    mem[1]  = 32'h8C12_0004;
    mem[2]  = 32'h0C00_000C;
    mem[3]  = 32'h8C13_0008;
    mem[12] = 32'h8C14_0000;

    reset = 1'b1;
    fif.stall_i = 1'b0;
    fif.flush_i = 1'b0;
    fif.redirect_i = 1'b0;
    fif.redirect_target_i = 32'd0;
    step();
    step();
    check("rst.pc", fif.pc_o, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

    reset = 1'b0;
    step();
    check("seq1.pc", fif.pc_o, 32'h4);
    check_ifid("seq1", 32'h8C10_0000, 32'h0, 32'h4, 1'b1, 32'd1);
    step();
    check("seq2.pc", fif.pc_o, 32'h8);
    check_ifid("seq2", 32'h8C12_0004, 32'h4, 32'h8, 1'b1, 32'd2);

    // JAL at 0x8 -> 0x30 with no bubble
    step();
    check("jal.pc", fif.pc_o, 32'h30);
    check_ifid("jal", 32'h0C00_000C, 32'h8, 32'hC, 1'b1, 32'd3);
    step();
    check("postjal.pc", fif.pc_o, 32'h34);
    check_ifid("postjal", 32'h8C14_0000, 32'h30, 32'h34, 1'b1, 32'd4);

    // redirect wins over stall; low address bits dropped
    fif.redirect_i = 1'b1;
    fif.redirect_target_i = 32'h2B;
    fif.stall_i = 1'b1;
    step();
    fif.redirect_i = 1'b0;
    fif.stall_i = 1'b0;
    check("redir.pc", fif.pc_o, 32'h28);
    check_ifid("redir", 32'h0, 32'h30, 32'h34, 1'b0, 32'd4);
    step();
    check("redir2.pc", fif.pc_o, 32'h2C);
    check_ifid("redir2", 32'h2000_000A, 32'h28, 32'h2C, 1'b1, 32'd5);

    // stall for 3 cycles with a real instruction in IF/ID
    fif.redirect_i = 1'b1;
    fif.redirect_target_i = 32'h10;
    step();
    fif.redirect_i = 1'b0;
    step();
    check("prestall.pc", fif.pc_o, 32'h14);
    check_ifid("prestall", 32'h2000_0004, 32'h10, 32'h14, 1'b1, 32'd6);
    fif.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.pc", fif.pc_o, 32'h14);
      check_ifid("stall", 32'h2000_0004, 32'h10, 32'h14, 1'b1, 32'd6);
    end
    fif.stall_i = 1'b0;
    step();
    check("unstall.pc", fif.pc_o, 32'h18);
    check_ifid("unstall", 32'h2000_0005, 32'h14, 32'h18, 1'b1, 32'd7);

    // flush alone at pc 0x10
    fif.redirect_i = 1'b1;
    fif.redirect_target_i = 32'h0C;
    step();
    fif.redirect_i = 1'b0;
    step();
    check("preflush.pc", fif.pc_o, 32'h10);
    check_ifid("preflush", 32'h8C13_0008, 32'h0C, 32'h10, 1'b1, 32'd8);
    fif.flush_i = 1'b1;
    step();
    check("flush.pc", fif.pc_o, 32'h14);
    check_ifid("flush", 32'h0, 32'h0C, 32'h10, 1'b0, 32'd8);

    // stall + flush: PC holds, bubble
    fif.stall_i = 1'b1;
    step();
    fif.stall_i = 1'b0;
    fif.flush_i = 1'b0;
    check("stflush.pc", fif.pc_o, 32'h14);
    check_ifid("stflush", 32'h0, 32'h0C, 32'h10, 1'b0, 32'd8);
    step();
    check("resume.pc", fif.pc_o, 32'h18);
    check_ifid("resume", 32'h2000_0005, 32'h14, 32'h18, 1'b1, 32'd9);

    // PC wrap at the top of the address space
    fif.redirect_i = 1'b1;
    fif.redirect_target_i = 32'hFFFF_FFFF;
    step();
    fif.redirect_i = 1'b0;
    check("wrapset.pc", fif.pc_o, 32'hFFFF_FFFC);
    step();
    check("wrap.pc", fif.pc_o, 32'h0);
    check_ifid("wrap", 32'h2000_003F, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd10);

    // reset mid-run dominates a concurrent redirect
    step();
    check("prerst.pc", fif.pc_o, 32'h4);
    reset = 1'b1;
    fif.redirect_i = 1'b1;
    fif.redirect_target_i = 32'h40;
    step();
    reset = 1'b0;
    fif.redirect_i = 1'b0;
    check("midrst.pc", fif.pc_o, 32'h0);
    check_ifid("midrst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
